des_iter_core: RTL

- Iterative DES encrypt/decrypt datapath that consumes the sixteen 48-bit subkeys produced by key_schedule.
- Accepts one 64-bit block plus a 64-bit key over a valid/ready handshake.
- Applies IP, then 16 Feistel rounds at ROUNDS_PER_CYCLE rounds per clock, then the 32-bit swap and FP.
- Returns the result over a valid/ready handshake. Sits between the host/bus wrapper and the key schedule.

---
 rtl/des_pkg.sv | 102 ++++++++++
 rtl/des_iter_core_round_f.sv | 21 ++
 rtl/key_schedule.sv | 27 ++
 rtl/des_iter_core.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES constants shared by the iterative core, its round function and the key schedule.
// Tables use the standard's 1-based, MSB-first bit numbering. Bit n of a W-bit vector is [W-n].
package des_pkg;

    localparam int DES_ROUNDS = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} des_state_e;

    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

    localparam int E_TAB [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32, 1};

    localparam int P_TAB [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18, 10, 2, 59, 51, 43, 35, 27,
        19, 11, 3, 60, 52, 44, 36, 63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36,
        29, 32};

    localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Row-major: entry [row*16 + col].
    localparam int SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7, 0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0, 15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10, 3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15, 13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7, 1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15, 13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4, 3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9, 14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14, 11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11, 10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6, 4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1, 13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2, 6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7, 1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8, 2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    function automatic logic [63:0] des_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[63-j] = x[64-IP_TAB[j]];
        return y;
    endfunction

    function automatic logic [63:0] des_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[63-j] = x[64-FP_TAB[j]];
        return y;
    endfunction

    function automatic logic [47:0] des_expand(input logic [31:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[47-j] = x[32-E_TAB[j]];
        return y;
    endfunction

    function automatic logic [31:0] des_perm_p(input logic [31:0] x);
        logic [31:0] y;
        for (int j = 0; j < 32; j++) y[31-j] = x[32-P_TAB[j]];
        return y;
    endfunction

    function automatic logic [55:0] des_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int j = 0; j < 56; j++) y[55-j] = x[64-PC1_TAB[j]];
        return y;
    endfunction

    function automatic logic [47:0] des_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[47-j] = x[56-PC2_TAB[j]];
        return y;
    endfunction

    // Outer bits pick the row, inner four bits the column.
    function automatic logic [3:0] des_sbox(input int box, input logic [5:0] six);
        return 4'(SBOX[box][{six[5], six[0], six[4:1]}]);
    endfunction

endpackage

// File: rtl/des_iter_core_round_f.sv
// DES Feistel function f(R, K): expansion, subkey XOR, S-boxes, P permutation.
module des_round_f
    import des_pkg::*;
(
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] f_o
);

    logic [47:0] x;
    logic [31:0] s;

    // Expand, mix in the subkey, substitute six bits to four per box, then permute
    always_comb begin
        x = des_expand(r_i) ^ k_i;
        s = '0;
        for (int b = 0; b < 8; b++) s[31-4*b -: 4] = des_sbox(b, x[47-6*b -: 6]);
        f_o = des_perm_p(s);
    end

endmodule

// File: rtl/key_schedule.sv
// DES key schedule: expands a 64-bit key (parity ignored) into sixteen 48-bit subkeys.
module key_schedule
    import des_pkg::*;
(
    input  logic [63:0]       key_i,
    output logic [15:0][47:0] subkeys_o
);

    logic [27:0] c, d;

    // Walk C/D through the sixteen left rotations, tapping PC-2 after each one
    always_comb begin
        {c, d}    = des_pc1(key_i);
        subkeys_o = '0;
        for (int n = 0; n < DES_ROUNDS; n++) begin
            if (SHIFT_TAB[n] == 1) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end else begin
                c = {c[25:0], c[27:26]};
                d = {d[25:0], d[27:26]};
            end
            subkeys_o[n] = des_pc2({c, d});
        end
    end

endmodule

// File: rtl/des_iter_core.sv
// Iterative DES encrypt/decrypt core, ROUNDS_PER_CYCLE Feistel rounds per clock.
module des_iter_core
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    input  logic        in_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
        ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
        $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [3:0] LAST_CNT = 4'(DES_ROUNDS - ROUNDS_PER_CYCLE);
    localparam logic [3:0] CNT_STEP = 4'(ROUNDS_PER_CYCLE % DES_ROUNDS);

    des_state_e  state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [63:0] key_q, key_d;
    logic        dec_q, dec_d;
    logic [3:0]  cnt_q, cnt_d;
    // Set once all sixteen rounds are in L/R; the following cycle applies FP.
    logic        fin_q, fin_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_data_q, out_data_d;

    logic [15:0][47:0] subkeys;
    logic [31:0]       l_c [ROUNDS_PER_CYCLE+1];
    logic [31:0]       r_c [ROUNDS_PER_CYCLE+1];

    key_schedule u_key_schedule (
        .key_i     (key_q),
        .subkeys_o (subkeys)
    );

    assign l_c[0] = l_q;
    assign r_c[0] = r_q;

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        logic [3:0]  idx;
        logic [47:0] k;
        logic [31:0] f;

        assign idx = cnt_q + 4'(g);
        // Decryption walks the same subkeys in reverse order.
        assign k   = dec_q ? subkeys[4'd15 - idx] : subkeys[idx];

        des_round_f u_round_f (
            .r_i (r_c[g]),
            .k_i (k),
            .f_o (f)
        );

        assign l_c[g+1] = r_c[g];
        assign r_c[g+1] = l_c[g] ^ f;
    end

    // Next-state: accept in IDLE, iterate rounds then FP in RUN, hold result in DONE
    always_comb begin
        state_d     = state_q;
        l_d         = l_q;
        r_d         = r_q;
        key_d       = key_q;
        dec_d       = dec_q;
        cnt_d       = cnt_q;
        fin_d       = fin_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    {l_d, r_d} = des_ip(in_data);
                    key_d      = in_key;
                    dec_d      = in_decrypt;
                    cnt_d      = '0;
                    fin_d      = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (fin_q) begin
                    out_data_d  = des_fp({r_q, l_q});
                    out_valid_d = 1'b1;
                    fin_d       = 1'b0;
                    state_d     = DONE;
                end else begin
                    l_d = l_c[ROUNDS_PER_CYCLE];
                    r_d = r_c[ROUNDS_PER_CYCLE];
                    if (cnt_q == LAST_CNT) begin
                        fin_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_STEP;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            key_q       <= '0;
            dec_q       <= 1'b0;
            cnt_q       <= '0;
            fin_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            l_q         <= l_d;
            r_q         <= r_d;
            key_q       <= key_d;
            dec_q       <= dec_d;
            cnt_q       <= cnt_d;
            fin_q       <= fin_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
